ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
ID/EX pipeline register plus the operand-selection and ALU-control logic that feeds the 32-bit ALU in the EX stage. Latches decoded instruction fields from ID, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and decodes the 3-bit ALU control. Supports stall (hold) and flush (insert bubble) from the hazard unit. Drives alu a/b/control directly, and forwards destination/write-enable/store data toward the EX/MEM register.

Parameters:
WIDTH, 32, datapath width of operands and results
REG_BITS, 5, register-index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all ID/EX state
stall  input  1  hold ID/EX contents this cycle
flush  input  1  load a bubble this cycle; takes priority over stall
id_valid  input  1  ID slot holds a real instruction
id_rs_data, id_rt_data  input  WIDTH  register-file read data
id_imm  input  WIDTH  sign-extended immediate
id_rs, id_rt, id_rd  input  REG_BITS  register indices
id_funct  input  6  R-type funct field
id_alu_op  input  2  00 add, 01 sub, 10 use funct, 11 or
id_alu_src  input  1  1 = operand B is immediate
id_reg_dst  input  1  1 = destination is rd, 0 = rt
id_reg_write  input  1  instruction writes the register file
exmem_reg_write  input  1  EX/MEM instruction writes back
exmem_rd  input  REG_BITS  EX/MEM destination
exmem_result  input  WIDTH  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB instruction writes back
memwb_rd  input  REG_BITS  MEM/WB destination
memwb_result  input  WIDTH  MEM/WB write-back value
alu_a, alu_b  output  WIDTH  ALU operands
alu_control  output  3  ALU operation code
ex_write_reg  output  REG_BITS  selected destination register
ex_reg_write  output  1  write enable toward EX/MEM (0 for a bubble)
ex_store_data  output  WIDTH  forwarded rt value (store data)
ex_valid  output  1  EX slot holds a real instruction
fwd_a_sel, fwd_b_sel  output  2  00 register, 10 EX/MEM, 01 MEM/WB (debug/coverage)

Behaviour:
- Registered state: valid, rs_data, rt_data, imm, rs, rt, rd, funct, alu_op, alu_src, reg_dst, reg_write.
- reset asserted (async): all state 0, so ex_valid=0, ex_reg_write=0, alu_control=000, ex_write_reg=0. alu_a/alu_b then equal any forwarded value, else 0.
- Each rising clk, priority: flush -> all state 0 (bubble); else stall -> hold; else load id_* fields. Latency ID->EX is one cycle.
- Forwarding is combinational from the registered rs/rt and the live exmem_*/memwb_* inputs. It applies during stall, so it tracks the advancing later stages.
- Forward A: if exmem_reg_write, exmem_rd!=0 and exmem_rd==rs -> exmem_result (sel 10). Else if memwb_reg_write, memwb_rd!=0 and memwb_rd==rs -> memwb_result (sel 01). Else rs_data (sel 00). EX/MEM wins when both match.
- Forward B: same rule on rt, giving fwd_rt. ex_store_data=fwd_rt. alu_b = imm if alu_src else fwd_rt. fwd_b_sel reports the rt selection regardless of alu_src.
- Register 0 is never forwarded.
- ex_write_reg = rd if reg_dst else rt.
- ex_reg_write = reg_write & valid.
- alu_control:
  - alu_op 00 -> 000; 01 -> 001; 11 -> 011.
  - alu_op 10 uses funct: 100000->000, 100010->001, 100100->010, 100101->011, 101010->111. Any other funct -> 000.
- flush and stall together: flush wins.
- reset mid-stall: state cleared immediately; stall ignored while reset is high.

Test Plan:
- Reset: assert reset mid-cycle with loaded state -> ex_valid=0, ex_reg_write=0, alu_control=000 immediately, before any clock edge.
- Plain R-type: load rs_data=5, rt_data=3, funct=100010, alu_op=10, reg_dst=1, rd=7 -> next cycle alu_a=5, alu_b=3, alu_control=001, ex_write_reg=7.
- Double forward: rs=rt=4; exmem_rd=4, exmem_result=0xAA, exmem_reg_write=1; memwb_rd=4, memwb_result=0xBB -> alu_a=alu_b=0xAA, sels=10. Drop exmem_reg_write -> both 0xBB, sels=01.
- r0 guard and immediate:
  - rs=0, exmem_rd=0, reg_write=1, exmem_result=0x55 -> alu_a=rs_data, fwd_a_sel=00.
  - alu_src=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC, while ex_store_data still shows the forwarded rt.
- Stall/flush:
  - Stall 2 cycles with changing id_* inputs -> outputs held.
  - stall+flush together -> ex_valid=0, ex_reg_write=0 next cycle.
- Decode sweep: all five funct codes plus funct=000000, and alu_op 00/01/11 -> 000, 001, 010, 011, 111, 000 and 000, 001, 011 respectively.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and ALU-control decode.
// Forwarding uses registered rs/rt against live EX/MEM and MEM/WB inputs, so it keeps tracking during a stall.
module ex_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [WIDTH-1:0]    id_rs_data,
  input  logic [WIDTH-1:0]    id_rt_data,
  input  logic [WIDTH-1:0]    id_imm,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic [5:0]          id_funct,
  input  logic [1:0]          id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic                id_reg_write,
  input  logic                exmem_reg_write,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]    exmem_result,
  input  logic                memwb_reg_write,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    memwb_result,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [2:0]          alu_control,
  output logic [REG_BITS-1:0] ex_write_reg,
  output logic                ex_reg_write,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic                ex_valid,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel
);
  localparam int SW = 3 * WIDTH + 3 * REG_BITS + 6 + 2 + 4;
  logic [SW-1:0]       st_q, st_d;
  logic                valid_q, alu_src_q, reg_dst_q, reg_write_q;
  logic [WIDTH-1:0]    rs_data_q, rt_data_q, imm_q, fwd_rt;
  logic [REG_BITS-1:0] rs_q, rt_q, rd_q;
  logic [5:0]          funct_q;
  logic [1:0]          alu_op_q;
  logic [2:0]          funct_ctl;
  logic                ex_a, wb_a, ex_b, wb_b;
  // Flush loads a bubble and beats stall; stall recirculates the current contents.
  always_comb st_d = flush ? '0 : stall ? st_q :
    {id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
     id_funct, id_alu_op, id_alu_src, id_reg_dst, id_reg_write};
  always_ff @(posedge clk or posedge reset)
    if (reset) st_q <= '0;
    else st_q <= st_d;
  assign {valid_q, rs_data_q, rt_data_q, imm_q, rs_q, rt_q, rd_q,
          funct_q, alu_op_q, alu_src_q, reg_dst_q, reg_write_q} = st_q;
  // Register 0 is hard-wired, so a write to it must never be forwarded.
  assign ex_a = exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q;
  assign wb_a = memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q;
  assign ex_b = exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q;
  assign wb_b = memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q;
  always_comb begin
    fwd_a_sel     = ex_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    fwd_b_sel     = ex_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
    alu_a         = ex_a ? exmem_result : wb_a ? memwb_result : rs_data_q;
    fwd_rt        = ex_b ? exmem_result : wb_b ? memwb_result : rt_data_q;
    alu_b         = alu_src_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    ex_write_reg  = reg_dst_q ? rd_q : rt_q;
    ex_reg_write  = reg_write_q & valid_q;
    ex_valid      = valid_q;
    funct_ctl     = funct_q == 6'b100000 ? 3'b000 :
                    funct_q == 6'b100010 ? 3'b001 :
                    funct_q == 6'b100100 ? 3'b010 :
                    funct_q == 6'b100101 ? 3'b011 :
                    funct_q == 6'b101010 ? 3'b111 : 3'b000;
    alu_control   = alu_op_q == 2'b00 ? 3'b000 :
                    alu_op_q == 2'b01 ? 3'b001 :
                    alu_op_q == 2'b11 ? 3'b011 : funct_ctl;
  end
endmodule
